// File: rtl/search_engine_arbiter.sv
// Two-requester round-robin front end for a shared element-search engine.
// Grants one requester, latches its array and drives the engine START/ACK
// handshake. Returns the engine result to the owner; a watchdog forces a
// not-found/error result if the engine never raises Done.
module search_engine_arbiter #(
   parameter int unsigned NELEM   = 10,
   parameter int unsigned DW      = 7,
   parameter int unsigned TIMEOUT = 127
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req,
   input  logic [NELEM*DW-1:0]   req_data0,
   input  logic [NELEM*DW-1:0]   req_data1,
   input  logic [1:0]            rsp_ack,
   output logic [1:0]            rsp_done,
   output logic [3:0]            rsp_location,
   output logic [6:0]            rsp_cycles,
   output logic                  rsp_err,
   output logic                  grant_id,
   output logic                  busy,
   output logic                  eng_start,
   output logic                  eng_ack,
   output logic [NELEM*DW-1:0]   eng_data,
   input  logic                  eng_done,
   input  logic [3:0]            eng_location,
   input  logic [6:0]            eng_cycles
);

   localparam int unsigned WDW = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_RESP,
      S_RELEASE,
      S_DRAIN
   } state_t;

   state_t         state;
   state_t         state_n;
   logic           ptr;
   logic [WDW-1:0] wd;
   logic           gnt_c;
   logic           timeout_c;

   // Pointer owner wins if requesting, otherwise the other requester.
   assign gnt_c     = req[ptr] ? ptr : ~ptr;
   // Final WAIT cycle without Done; Done in the same cycle takes precedence.
   assign timeout_c = (state == S_WAIT) && (wd == WDW'(TIMEOUT - 1)) && !eng_done;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    if (|req) state_n = S_LOAD;
         S_LOAD:    state_n = S_WAIT;
         S_WAIT:    if (eng_done || timeout_c) state_n = S_RESP;
         S_RESP:    if (rsp_ack[grant_id]) state_n = S_RELEASE;
         S_RELEASE: state_n = rsp_err ? S_IDLE : S_DRAIN;
         S_DRAIN:   if (!eng_done) state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   // Handshake and status outputs, registered from the upcoming state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         eng_start <= 1'b0;
         eng_ack   <= 1'b0;
         busy      <= 1'b0;
         rsp_done  <= 2'b00;
      end else begin
         eng_start <= (state_n == S_LOAD);
         eng_ack   <= (state_n == S_RELEASE);
         busy      <= (state_n != S_IDLE);
         rsp_done  <= (state_n == S_RESP) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
      end
   end

   // Grant owner and array latch, taken only when leaving IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_id <= 1'b0;
         eng_data <= '0;
      end else if (state == S_IDLE && |req) begin
         grant_id <= gnt_c;
         eng_data <= gnt_c ? req_data1 : req_data0;
      end
   end

   // Watchdog: cleared in LOAD, counts every WAIT cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                wd <= '0;
      else if (state == S_LOAD)  wd <= '0;
      else if (state == S_WAIT)  wd <= wd + WDW'(1);
   end

   // Result capture on leaving WAIT; held until the next capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_location <= 4'h0;
         rsp_cycles   <= 7'h00;
         rsp_err      <= 1'b0;
      end else if (state == S_WAIT) begin
         if (eng_done) begin
            rsp_location <= eng_location;
            rsp_cycles   <= eng_cycles;
            rsp_err      <= 1'b0;
         end else if (timeout_c) begin
            rsp_location <= 4'hF;
            rsp_cycles   <= 7'h7F;
            rsp_err      <= 1'b1;
         end
      end
   end

   // Round-robin pointer hands priority to the other requester after service.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                     ptr <= 1'b0;
      else if (state != S_IDLE && state_n == S_IDLE)  ptr <= ~grant_id;
   end

endmodule
